// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
package mips_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned ADDR_W = 32;

   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
   localparam logic [INST_W-1:0] NOP_INST = INST_W'(0);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   // Force a byte address onto a word boundary.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address and hands
// fetched words to decode through a one-entry valid/ready buffer.
module ifetch_ctrl
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned ROM_WORDS   = 32,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        fetch_fault,
   output logic [31:0] fetch_count
);

   localparam int unsigned CNT_W = 32;
   localparam int unsigned WC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int unsigned LIM_W = ADDR_W + 1;

   // One extra bit so a full 4 GiB ROM limit cannot wrap to zero.
   localparam logic [LIM_W-1:0] ROM_LIMIT = LIM_W'(ROM_WORDS) << 2;
   localparam logic [WC_W-1:0]  WAIT_MAX  = WC_W'(WAIT_CYCLES);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [WC_W-1:0]   r_wait_cnt;
   logic [INST_W-1:0] r_inst;
   logic [ADDR_W-1:0] r_inst_pc;
   logic              r_inst_valid;
   logic              r_fault;
   logic [CNT_W-1:0]  r_count;

   logic              w_in_range;
   logic              w_rdy;
   logic              w_free;
   logic              w_xfer;
   logic              w_capture;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [WC_W-1:0]   w_wait_nxt;
   logic              w_valid_nxt;
   logic              w_fault_nxt;
   logic [CNT_W-1:0]  w_count_nxt;

   assign w_in_range = ({1'b0, r_pc} < ROM_LIMIT);
   assign w_rdy      = (r_state == RUN) && (r_wait_cnt == WAIT_MAX);
   assign w_free     = !r_inst_valid || inst_ready;
   assign w_xfer     = r_inst_valid && inst_ready;
   assign w_capture  = w_rdy && w_free && !redirect && !halt && w_in_range;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_state_nxt;
   end

   // Next state: redirect wins, then the range fault, then halt; FAULT is sticky.
   always_comb begin
      w_state_nxt = r_state;
      if (redirect) begin
         w_state_nxt = halt ? HALT : RUN;
      end else if (!w_in_range) begin
         w_state_nxt = FAULT;
      end else if (r_state != FAULT) begin
         w_state_nxt = halt ? HALT : RUN;
      end
   end

   // Next values for the PC, wait counter, buffer and status registers.
   always_comb begin
      w_pc_nxt    = r_pc;
      w_wait_nxt  = r_wait_cnt;
      w_valid_nxt = r_inst_valid;
      w_fault_nxt = r_fault;
      w_count_nxt = r_count + CNT_W'(w_xfer);
      if (w_xfer) w_valid_nxt = 1'b0;
      if (redirect) begin
         w_pc_nxt    = word_align(redirect_pc);
         w_wait_nxt  = '0;
         w_valid_nxt = 1'b0;
         w_fault_nxt = 1'b0;
      end else begin
         if (!w_in_range) w_fault_nxt = 1'b1;
         if (w_capture) begin
            w_pc_nxt    = r_pc + PC_STEP;
            w_wait_nxt  = '0;
            w_valid_nxt = 1'b1;
         end else if ((r_state == RUN) && !halt) begin
            if (r_wait_cnt != WAIT_MAX) w_wait_nxt = r_wait_cnt + WC_W'(1);
         end else if (r_state != RUN) begin
            w_wait_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_wait_cnt   <= '0;
         r_inst       <= NOP_INST;
         r_inst_pc    <= '0;
         r_inst_valid <= 1'b0;
         r_fault      <= 1'b0;
         r_count      <= '0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_wait_cnt   <= w_wait_nxt;
         r_inst_valid <= w_valid_nxt;
         r_fault      <= w_fault_nxt;
         r_count      <= w_count_nxt;
         if (w_capture) begin
            r_inst    <= rom_data;
            r_inst_pc <= r_pc;
         end
      end
   end

   assign rom_addr    = r_pc;
   assign inst        = r_inst;
   assign inst_pc     = r_inst_pc;
   assign inst_valid  = r_inst_valid;
   assign fetch_fault = r_fault;
   assign fetch_count = r_count;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: a zero-wait and a two-wait instance share stimulus and
// are each tracked by a transaction-level fetch model.
module tb_ifetch_ctrl;

   localparam int unsigned NW    = 32;
   localparam logic [31:0] LIMIT = 32'h80;
   localparam int MRUN   = 0;
   localparam int MHALT  = 1;
   localparam int MFAULT = 2;

   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_addr;
      logic [31:0] exp_cnt;
   } vec_t;

   logic        clk, rst, ready, redir, halt;
   logic [31:0] rpc;
   logic [31:0] addr0, data0, inst0, ipc0, cnt0;
   logic        valid0, fault0;
   logic [31:0] addr2, data2, inst2, ipc2, cnt2;
   logic        valid2, fault2;
   logic [31:0] rom [NW];

   int checks   = 0;
   int failures = 0;

   // Reference model state per instance (0: no wait, 1: two wait cycles).
   int          m_waitmax [2];
   logic [31:0] m_pc      [2];
   int          m_wait    [2];
   int          m_mode    [2];
   logic        m_fault   [2];
   logic [31:0] m_count   [2];
   logic        m_has     [2];
   logic [31:0] m_word    [2];
   logic [31:0] m_ipc     [2];

   assign data0 = rom[addr0[6:2]];
   assign data2 = rom[addr2[6:2]];

   ifetch_ctrl #(.RESET_PC(32'h0), .ROM_WORDS(32), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .rom_addr(addr0), .rom_data(data0), .inst(inst0),
      .inst_pc(ipc0), .inst_valid(valid0), .inst_ready(ready), .redirect(redir),
      .redirect_pc(rpc), .halt(halt), .fetch_fault(fault0), .fetch_count(cnt0));

   ifetch_ctrl #(.RESET_PC(32'h0), .ROM_WORDS(32), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .rom_addr(addr2), .rom_data(data2), .inst(inst2),
      .inst_pc(ipc2), .inst_valid(valid2), .inst_ready(ready), .redirect(redir),
      .redirect_pc(rpc), .halt(halt), .fetch_fault(fault2), .fetch_count(cnt2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = 32'h0; m_wait[k] = 0; m_mode[k] = MRUN; m_fault[k] = 1'b0;
         m_count[k] = 32'h0; m_has[k] = 1'b0; m_word[k] = 32'h0; m_ipc[k] = 32'h0;
      end
   endtask

   // One clock of fetch behaviour: drain, then redirect / fault / halt / fetch.
   task automatic model_step(input int k, input logic rd, input logic re,
                             input logic [31:0] tp, input logic hl);
      logic inr;
      inr = (m_pc[k] < LIMIT);
      if (m_has[k] && rd) begin
         m_count[k] = m_count[k] + 32'd1;
         m_has[k]   = 1'b0;
      end
      if (re) begin
         m_has[k] = 1'b0; m_pc[k] = tp & ~32'h3; m_wait[k] = 0;
         m_fault[k] = 1'b0; m_mode[k] = hl ? MHALT : MRUN;
         return;
      end
      if (!inr) begin
         m_mode[k] = MFAULT; m_fault[k] = 1'b1;
         return;
      end
      if (m_mode[k] == MFAULT) return;
      if (m_mode[k] == MRUN && !hl) begin
         if (m_wait[k] == m_waitmax[k] && !m_has[k]) begin
            m_has[k] = 1'b1; m_word[k] = rom[m_pc[k][6:2]]; m_ipc[k] = m_pc[k];
            m_pc[k] = m_pc[k] + 32'd4; m_wait[k] = 0;
         end else if (m_wait[k] < m_waitmax[k]) begin
            m_wait[k]++;
         end
      end else if (m_mode[k] == MHALT) begin
         m_wait[k] = 0;
      end
      m_mode[k] = hl ? MHALT : MRUN;
   endtask

   task automatic check_model(input int k);
      logic [31:0] a_addr, a_inst, a_ipc, a_cnt;
      logic        a_v, a_f;
      if (k == 0) begin
         a_addr = addr0; a_inst = inst0; a_ipc = ipc0; a_cnt = cnt0; a_v = valid0; a_f = fault0;
      end else begin
         a_addr = addr2; a_inst = inst2; a_ipc = ipc2; a_cnt = cnt2; a_v = valid2; a_f = fault2;
      end
      chk($sformatf("model%0d rom_addr", k), a_addr, m_pc[k]);
      chk($sformatf("model%0d inst_valid", k), 32'(a_v), 32'(m_has[k]));
      chk($sformatf("model%0d fetch_fault", k), 32'(a_f), 32'(m_fault[k]));
      chk($sformatf("model%0d fetch_count", k), a_cnt, m_count[k]);
      if (m_has[k]) begin
         chk($sformatf("model%0d inst_pc", k), a_ipc, m_ipc[k]);
         chk($sformatf("model%0d inst", k), a_inst, m_word[k]);
      end
   endtask

   // Called at a falling edge: apply inputs across one rising edge, then compare.
   task automatic step(input logic rd, input logic re, input logic [31:0] tp, input logic hl);
      ready = rd; redir = re; rpc = tp; halt = hl;
      model_step(0, rd, re, tp, hl);
      model_step(1, rd, re, tp, hl);
      @(negedge clk);
      check_model(0);
      check_model(1);
   endtask

   task automatic do_reset();
      rst = 1'b1; ready = 1'b0; redir = 1'b0; rpc = 32'h0; halt = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_model(0);
      check_model(1);
      chk("reset inst", inst0, 32'h0);
      chk("reset inst_pc", ipc0, 32'h0);
   endtask

   initial begin
      vec_t tv [11];
      logic [31:0] tp;
      m_waitmax[0] = 0;
      m_waitmax[1] = 2;
      for (int i = 0; i < int'(NW); i++) rom[i] = 32'hA500_0000 | (32'(i) << 8) | 32'(i * 7);
      rom[0] = 32'h2001_0008;
      rom[1] = 32'h3402_000C;
      rom[2] = 32'h0022_1820;
      rst = 1'b1; ready = 1'b0; redir = 1'b0; rpc = 32'h0; halt = 1'b0;

      // Streaming, backpressure and a misaligned redirect on the zero-wait instance.
      tv[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 32'h04, 32'd0};
      tv[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h08, 32'd1};
      tv[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0C, 32'd2};
      tv[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0C, 32'd2};
      tv[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0C, 32'd2};
      tv[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0C, 32'd2};
      tv[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h10, 32'd3};
      tv[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h10, 32'd3};
      tv[8]  = '{1'b0, 1'b1, 32'h37, 1'b0, 32'h0C, 32'h34, 32'd3};
      tv[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h34, 32'h38, 32'd3};
      tv[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h38, 32'h3C, 32'd4};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         step(tv[i].ready, tv[i].redir, tv[i].rpc, 1'b0);
         chk($sformatf("vec%0d inst_valid", i), 32'(valid0), 32'(tv[i].exp_valid));
         chk($sformatf("vec%0d rom_addr", i), addr0, tv[i].exp_addr);
         chk($sformatf("vec%0d fetch_count", i), cnt0, tv[i].exp_cnt);
         if (tv[i].exp_valid) begin
            chk($sformatf("vec%0d inst_pc", i), ipc0, tv[i].exp_pc);
            chk($sformatf("vec%0d inst", i), inst0, rom[tv[i].exp_pc[6:2]]);
         end
      end

      // Two wait cycles: one capture every third clock.
      do_reset();
      for (int n = 1; n <= 9; n++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0);
         chk($sformatf("wait2 n%0d valid", n), 32'(valid2), 32'((n % 3) == 0));
         chk($sformatf("wait2 n%0d rom_addr", n), addr2, 32'(4 * (n / 3)));
         if ((n % 3) == 0) chk($sformatf("wait2 n%0d inst_pc", n), ipc2, 32'(4 * (n / 3 - 1)));
      end

      // Run off the end of the ROM, drain the last word, then recover by redirect.
      step(1'b1, 1'b1, 32'h78, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("fault edge rom_addr", addr0, 32'h80);
      chk("fault edge inst_pc", ipc0, 32'h7C);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk("fault set", 32'(fault0), 32'd1);
      chk("fault hold valid", 32'(valid0), 32'd1);
      chk("fault hold inst_pc", ipc0, 32'h7C);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("fault drained", 32'(valid0), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         chk($sformatf("fault idle%0d valid", i), 32'(valid0), 32'd0);
         chk($sformatf("fault idle%0d rom_addr", i), addr0, 32'h80);
      end
      step(1'b1, 1'b1, 32'h0, 1'b0);
      chk("fault cleared", 32'(fault0), 32'd0);
      chk("fault redirect rom_addr", addr0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("fault resume valid", 32'(valid0), 32'd1);
      chk("fault resume inst_pc", ipc0, 32'h0);

      // Halt at 0x10, then an asynchronous reset between clock edges.
      step(1'b0, 1'b1, 32'h10, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1);
         chk($sformatf("halt%0d rom_addr", i), addr0, 32'h10);
         chk($sformatf("halt%0d valid", i), 32'(valid0), 32'd0);
      end
      #2;
      rst = 1'b1; ready = 1'b0; halt = 1'b0;
      #1;
      chk("async rst rom_addr", addr0, 32'h0);
      chk("async rst valid", 32'(valid0), 32'd0);
      chk("async rst count", cnt0, 32'h0);
      chk("async rst fault", 32'(fault0), 32'd0);
      chk("async rst inst_pc", ipc0, 32'h0);
      chk("async rst inst", inst0, 32'h0);
      chk("async rst wait2 rom_addr", addr2, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("post rst first capture valid", 32'(valid0), 32'd1);
      chk("post rst first capture inst_pc", ipc0, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) tp = $urandom();
         else tp = 32'($urandom_range(0, 40) * 4 + $urandom_range(0, 3));
         step(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 19) == 0), tp,
              logic'($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
